arbiter_sync_multi: RTL

- N-channel synchronous memory arbiter. Successor to the fixed 4-port priority arbiter in front of the SDRAM controller.
- Generalises channel count, address and data widths.
- Adds a selectable round-robin mode, bounded grant hold (burst lock) and registered per-channel response routing by ID.
- Sits between requesters (TFT, display, capture and future DMA) and the single SDRAM controller port, all in the clkSYS domain.

---
 rtl/arbiter_sync_multi.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/arbiter_sync_multi.sv
// arbiter_sync_multi
// ------------------
// N-channel synchronous arbiter in front of the single SDRAM controller port.
// Every signal here is in the clkSYS domain.
//
// Selection:
//   MODE 0 : fixed priority, channel 0 highest.
//   MODE 1 : round-robin. The search starts one past the last winner.
//   Optional `ARB_AGE_EN: a channel that has waited AGE_LIMIT cycles wins
//   over the MODE rule. Among aged channels the lowest index wins.
//
// Grant hold: a grant stays on one channel until that channel drops req_i
// (in a cycle without mem_ack) or until HOLD acks have been taken
// (HOLD = 0 means no limit). Each release costs one idle bubble cycle.
//
// Handshake: the granted channel's request is offered as mem_req. One
// transfer happens in each cycle where mem_req and mem_ack are both high.
// That transfer is reflected combinationally on ack_o[grant]. The requester
// must hold addr/data/wr stable while req_i is high and not yet acked.
//
// Ports:
//   clkSYS, reset          clock, asynchronous active-high reset
//   req_i/addr_i/data_i/wr_i  per-channel request bundle (channel i at slice i)
//   ack_o                  per-channel accept strobe
//   mem_req/addr/data/wr/id   request to the memory controller
//   mem_ack                controller accepted the current request
//   rsp_valid/id/data      read response from the controller
//   valid_o/data_o         registered read response routed by ID
//   busy                   a grant is active
//   state_dbg              FSM state (0 = IDLE, 1 = GRANT)
//
// Build option: define ARB_AGE_EN to enable starvation ageing.
module arbiter_sync_multi #(
  parameter int AN        = 24,
  parameter int DN        = 16,
  parameter int N         = 4,
  parameter int IW        = 2,
  parameter int MODE      = 0,
  parameter int HOLD      = 8,
  parameter int AGE_LIMIT = 64
) (
  input  logic            clkSYS,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic [N*AN-1:0] addr_i,
  input  logic [N*DN-1:0] data_i,
  input  logic [N-1:0]    wr_i,
  output logic [N-1:0]    ack_o,
  output logic            mem_req,
  output logic [AN-1:0]   mem_addr,
  output logic [DN-1:0]   mem_data,
  output logic            mem_wr,
  output logic [IW-1:0]   mem_id,
  input  logic            mem_ack,
  input  logic            rsp_valid,
  input  logic [IW-1:0]   rsp_id,
  input  logic [DN-1:0]   rsp_data,
  output logic [N-1:0]    valid_o,
  output logic [DN-1:0]   data_o,
  output logic            busy,
  output logic [0:0]      state_dbg
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  logic [0:0]    state;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic [HW-1:0] hold_cnt;
  logic          grant_req;

`ifdef ARB_AGE_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] age_cnt [N];
`endif

  // Mux of the granted channel. The mux stays live outside GRANT, so the
  // controller sees the last granted channel's fields while mem_req is low.
  always_comb begin
    grant_req = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    mem_wr    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant == IW'(i)) begin
        grant_req = req_i[i];
        mem_addr  = addr_i[i*AN +: AN];
        mem_data  = data_i[i*DN +: DN];
        mem_wr    = wr_i[i];
      end
    end
  end

  // Winner search. Each loop runs from the lowest priority to the highest
  // priority, so the last match that is written is the winner.
  always_comb begin
    winner = '0;
    if (MODE == 0) begin
      for (int i = N - 1; i >= 0; i--)
        if (req_i[i]) winner = IW'(i);
    end else begin
      for (int k = N; k >= 1; k--)
        if (req_i[(int'(rr_ptr) + k) % N]) winner = IW'((int'(rr_ptr) + k) % N);
    end
`ifdef ARB_AGE_EN
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i] && (age_cnt[i] == AW'(AGE_LIMIT))) winner = IW'(i);
`endif
  end

  assign busy      = (state == GRANT);
  assign mem_req   = busy && grant_req;
  assign mem_id    = grant;
  assign state_dbg = state;

  always_comb begin
    ack_o = '0;
    for (int i = 0; i < N; i++)
      ack_o[i] = busy && (grant == IW'(i)) && mem_ack;
  end

  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      hold_cnt <= '0;
      rr_ptr   <= IW'(N - 1);
    end else if (state == IDLE) begin
      if (|req_i) begin
        grant <= winner;
        state <= GRANT;
        if (MODE == 1) rr_ptr <= winner;
      end
    end else begin
      if (mem_ack) begin
        // The counter only reaches HOLD-1 before this ack releases the grant.
        if ((HOLD != 0) && (hold_cnt == HW'(HOLD - 1))) begin
          state    <= IDLE;
          hold_cnt <= '0;
        end else if (HOLD != 0) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else if (!grant_req) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end
    end
  end

`ifdef ARB_AGE_EN
  // Each counter saturates at AGE_LIMIT and clears when its channel wins.
  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) age_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if ((state == IDLE) && (|req_i) && (winner == IW'(i)))
          age_cnt[i] <= '0;
        else if (req_i[i] && !((state == GRANT) && (grant == IW'(i))) &&
                 (age_cnt[i] != AW'(AGE_LIMIT)))
          age_cnt[i] <= age_cnt[i] + 1'b1;
      end
    end
  end
`endif

  // The response path ignores grant state. IDs at or above N match no bit,
  // so those responses are dropped.
  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      valid_o <= '0;
      data_o  <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        valid_o[i] <= rsp_valid && (rsp_id == IW'(i));
      if (rsp_valid) data_o <= rsp_data;
    end
  end

endmodule
